// File: rtl/vdma_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vdma_pkg
//  Purpose  : Shared limits, read-pipeline encodings and a constant clog2
//             helper for the VDMA line FIFO and its storage.
//  Revision : 1.0 - initial release
// ============================================================================
package vdma_pkg;

   // Legal parameter ranges for the line FIFO
   localparam int DWIDTH_MIN     = 8;
   localparam int DWIDTH_MAX     = 256;
   localparam int DEPTH_LOG2_MIN = 4;
   localparam int DEPTH_LOG2_MAX = 12;

   // RAM read pipeline encodings (value of PIPE)
   localparam int PIPE_NONE = 0;   // data one cycle after the read address
   localparam int PIPE_REG  = 1;   // extra output register, two cycles

   // Ceiling log2, usable in constant expressions
   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v      = value - 1;
      while (v > 0) begin
         result = result + 1;
         v      = v >>> 1;
      end
      return result;
   endfunction

endpackage
`default_nettype wire

// File: rtl/vdma_sdp_ram.sv
`default_nettype none
// ============================================================================
//  Module   : vdma_sdp_ram
//  Purpose  : Simple dual-port RAM, single clock, registered read with an
//             optional second output register. Read data only advances when
//             enabled so the downstream pipeline can stall. No reset on
//             storage or read registers so the array maps onto block RAM.
//  Revision : 1.0 - initial release
// ============================================================================
module vdma_sdp_ram
   import vdma_pkg::*;
#(
   parameter int DWIDTH     = 32,
   parameter int DEPTH_LOG2 = 7,
   parameter int PIPE       = PIPE_REG
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic [DEPTH_LOG2-1:0] waddr_i,
   input  logic [DWIDTH-1:0]     wdata_i,
   input  logic                  re_i,
   input  logic [DEPTH_LOG2-1:0] raddr_i,
   input  logic                  pipe_en_i,
   output logic [DWIDTH-1:0]     rdata_o
);

   localparam int DEPTH = 2**DEPTH_LOG2;

   logic [DWIDTH-1:0] mem_q [DEPTH];
   logic [DWIDTH-1:0] rd_q;

   // Write port
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Synchronous read port; holds its value while no read is issued
   always_ff @(posedge clk_i) begin
      if (re_i) begin
         rd_q <= mem_q[raddr_i];
      end
   end

   generate
      if (PIPE == PIPE_REG) begin : g_out_reg
         logic [DWIDTH-1:0] pipe_q;

         // Optional output register, loaded when the first stage moves on
         always_ff @(posedge clk_i) begin
            if (pipe_en_i) begin
               pipe_q <= rd_q;
            end
         end

         assign rdata_o = pipe_q;
      end else begin : g_no_out_reg
         logic unused_pipe_en;
         assign unused_pipe_en = pipe_en_i;
         assign rdata_o        = rd_q;
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/vdma_line_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : vdma_line_fifo
//  Purpose  : First-word-fall-through line FIFO. Words are stored in a block
//             RAM and prefetched through a stallable pipeline (RAM read,
//             optional RAM output register, head register) so that the head
//             word is always presented and sustained pops run at one word
//             per cycle. COUNT includes words sitting in the prefetch stages.
//  Revision : 1.0 - initial release
// ============================================================================
module vdma_line_fifo
   import vdma_pkg::*;
#(
   parameter int DWIDTH     = 32,
   parameter int DEPTH_LOG2 = 7,
   parameter int PIPE       = PIPE_REG,
   parameter int AFULL_LVL  = (2**DEPTH_LOG2) - 4,
   parameter int AEMPTY_LVL = 4
) (
   input  logic                  CLOCK,
   input  logic                  RESET,
   input  logic                  CLEAR,
   input  logic [DWIDTH-1:0]     WDATA,
   input  logic                  WEN,
   output logic                  FULL,
   output logic                  AFULL,
   input  logic                  REN,
   output logic [DWIDTH-1:0]     RDATA,
   output logic                  EMPTY,
   output logic                  AEMPTY,
   output logic [DEPTH_LOG2:0]   COUNT,
   output logic                  OVERFLOW,
   output logic                  UNDERFLOW
);

   localparam int DEPTH = 2**DEPTH_LOG2;
   localparam int CNT_W = clog2(DEPTH + 1);

   // Pointers and occupancy
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;     // all stored words
   logic [CNT_W-1:0]      ram_cnt_q, ram_cnt_d; // words not yet read from RAM

   // Prefetch pipeline
   logic                  s1_vld_q, s1_vld_d;   // RAM read register holds a word
   logic                  head_vld_q, head_vld_d;
   logic [DWIDTH-1:0]     head_q, head_d;
   logic [DWIDTH-1:0]     ram_rdata;

   // Status flags
   logic                  full_q, full_d;
   logic                  afull_q, afull_d;
   logic                  aempty_q, aempty_d;
   logic                  ovf_q, udf_q;

   // Handshake and pipeline control
   logic                  wr_acc;
   logic                  pop;
   logic                  head_rdy;
   logic                  s1_adv;
   logic                  head_ld;
   logic                  issue;
   logic                  flush;

   assign flush    = RESET | CLEAR;
   assign wr_acc   = WEN & ~full_q;
   assign pop      = REN & head_vld_q;
   assign head_rdy = ~head_vld_q | pop;

   generate
      if (PIPE == PIPE_REG) begin : g_pipe_stage
         logic s2_vld_q, s2_vld_d;

         assign s1_adv   = s1_vld_q & (~s2_vld_q | head_rdy);
         assign head_ld  = s2_vld_q & head_rdy;
         assign s2_vld_d = s1_adv | (s2_vld_q & ~head_rdy);

         // Valid bit of the RAM output register; flushing drops in-flight data
         always_ff @(posedge CLOCK) begin
            if (flush) begin
               s2_vld_q <= 1'b0;
            end else begin
               s2_vld_q <= s2_vld_d;
            end
         end
      end else begin : g_no_pipe_stage
         assign s1_adv  = s1_vld_q & head_rdy;
         assign head_ld = s1_vld_q & head_rdy;
      end
   endgenerate

   // Next-state for pointers, counters, prefetch valids and registered flags
   always_comb begin
      issue      = (ram_cnt_q != '0) & (~s1_vld_q | s1_adv);
      wr_ptr_d   = wr_ptr_q + DEPTH_LOG2'(wr_acc);
      rd_ptr_d   = rd_ptr_q + DEPTH_LOG2'(issue);
      count_d    = count_q + CNT_W'(wr_acc) - CNT_W'(pop);
      ram_cnt_d  = ram_cnt_q + CNT_W'(wr_acc) - CNT_W'(issue);
      s1_vld_d   = issue | (s1_vld_q & ~s1_adv);
      head_vld_d = head_ld | (head_vld_q & ~pop);
      head_d     = head_ld ? ram_rdata : head_q;
      full_d     = (count_d == CNT_W'(DEPTH));
      afull_d    = (int'(count_d) >= AFULL_LVL);
      aempty_d   = (int'(count_d) <= AEMPTY_LVL);
   end

   // State registers; CLEAR behaves like reset for everything but the sticky flags
   always_ff @(posedge CLOCK) begin
      if (flush) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         ram_cnt_q  <= '0;
         s1_vld_q   <= 1'b0;
         head_vld_q <= 1'b0;
         head_q     <= '0;
         full_q     <= 1'b0;
         afull_q    <= 1'b0;
         aempty_q   <= 1'b1;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         ram_cnt_q  <= ram_cnt_d;
         s1_vld_q   <= s1_vld_d;
         head_vld_q <= head_vld_d;
         head_q     <= head_d;
         full_q     <= full_d;
         afull_q    <= afull_d;
         aempty_q   <= aempty_d;
      end
   end

   // Sticky error flags, cleared only by RESET
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_q | (WEN & full_q);
         udf_q <= udf_q | (REN & ~head_vld_q);
      end
   end

   vdma_sdp_ram #(
      .DWIDTH     (DWIDTH),
      .DEPTH_LOG2 (DEPTH_LOG2),
      .PIPE       (PIPE)
   ) u_ram (
      .clk_i      (CLOCK),
      .we_i       (wr_acc),
      .waddr_i    (wr_ptr_q),
      .wdata_i    (WDATA),
      .re_i       (issue),
      .raddr_i    (rd_ptr_q),
      .pipe_en_i  (s1_adv),
      .rdata_o    (ram_rdata)
   );

   assign FULL      = full_q;
   assign AFULL     = afull_q;
   assign AEMPTY    = aempty_q;
   assign EMPTY     = ~head_vld_q;
   assign RDATA     = head_q;
   assign COUNT     = count_q;
   assign OVERFLOW  = ovf_q;
   assign UNDERFLOW = udf_q;

endmodule
`default_nettype wire
